rr_sticky_arbiter: RTL and testbench
====================================

# rr_sticky_arbiter

- Registered round-robin arbiter for N agents on a shared resource.
- Produces a one-hot grant one cycle after a request.
- A grant is sticky: the holder keeps it for as long as it keeps requesting. When the holder releases, the next requester in rotation receives the grant.
- Sits between the requesting agents and the shared resource; the team's arbiter assertion checker binds directly to its `r`/`g` ports. The block also tracks grant hold time and flags agents that exceed the hold limit.

## Interface

Parameters:
- `N` — default 8 — number of agents; must be ≥ 2.
- `MAX_HOLD` — default 255 — limit on consecutive cycles of granted-and-requesting before `hold_timeout` asserts.
- `CW` — default `$clog2(MAX_HOLD+1)` — hold counter width.

Ports:
- `clock` — in — 1 — single clock; all state updates on rising edge.
- `reset_n` — in — 1 — asynchronous, active-low reset.
- `r` — in — [0:N-1] — request vector; bit i is agent i. Bit order is ascending, so agent 0 is the leftmost bit.
- `g` — out — [0:N-1] — registered grant vector; one-hot or zero.
- `grant_valid` — out — 1 — registered; equals `|g`.
- `grant_id` — out — `$clog2(N)` — registered index of the granted agent; 0 when `grant_valid` is 0.
- `hold_cnt` — out — CW — registered count of consecutive cycles the current holder has been granted while requesting.
- `hold_timeout` — out — 1 — registered level; high while `hold_cnt == MAX_HOLD`.

## Operation

- State:
  - `g` register.
  - Round-robin pointer `ptr` (0..N-1): the index with top priority on the next fresh arbitration.
  - Hold counter `hold_cnt`.
- Next-grant decision at each rising edge, using `r` and `g` as sampled at that edge:
  - **Keep:** `g` nonzero and `r & g` nonzero. `g` is unchanged and `ptr` is unchanged.
  - **Fresh:** otherwise, if `|r`, grant the first set bit of `r` searching `ptr`, `ptr+1`, … mod N. Set `ptr` to (winner+1) mod N.
  - **Idle:** otherwise `g` becomes 0 and `ptr` is unchanged.
- A holder that drops its request loses the grant on the next edge. Re-arbitration happens in that same edge; there is no idle gap cycle when other agents are requesting.
- A fresh grant goes only to an agent whose `r` bit was sampled high.
- A single requester always wins a fresh arbitration, regardless of `ptr`.
- `hold_cnt`:
  - On the edge that takes the Keep branch: `hold_cnt + 1`, saturating at `MAX_HOLD`.
  - On a Fresh branch: 1.
  - On Idle: 0.
- `hold_timeout = (hold_cnt == MAX_HOLD)`, registered alongside `hold_cnt`. It is a status output only: the block never preempts the holder.
- `grant_id` and `grant_valid` are derived from the next `g` value and registered together with it.
- Reset (`reset_n` low, any time, including mid-hold) immediately and asynchronously forces:
  - `g` = 0, `grant_valid` = 0, `grant_id` = 0
  - `ptr` = 0
  - `hold_cnt` = 0, `hold_timeout` = 0

## Timing

- Latency is 1 cycle:
  - Request sampled at edge k → grant visible after edge k.
  - Release sampled at edge k → grant cleared or moved after edge k.
- Invariants, checked whenever not in reset:
  - `$onehot0(g)` holds.
  - `|r |=> |g` holds.
  - `g[i] |-> $past(r[i])` holds.
  - If `r == $past(r)`, then `g` is stable on the next cycle.
- Every output is driven from a register; there are no combinational paths from `r` to any output.
- Fairness bound: an agent that requests continuously is granted after at most N-1 other grants.
- After `reset_n` deasserts, the first sampling edge arbitrates with `ptr = 0`.
- Simultaneous release by the holder and a new request: the new request is arbitrated on that same edge.
- When the holder is at index N-1, `ptr` wraps to 0.

## Test plan

- **Reset then single requester:** reset, then `r = 8'b0010_0000` (agent 2) → `g = 8'b0010_0000` one cycle later, `grant_id = 2`, `hold_cnt = 1`.
- **Rotation:** all requesters held, `r = 8'hFF` from reset; each holder drops its request for exactly one cycle after holding → grants go to agents 0, 1, 2, …, 7, 0 in order, with no zero-grant cycles.
- **Stickiness:**
  - Agent 5 is granted.
  - Agents 1 and 7 then also request, and agent 5 keeps requesting for 10 cycles → `g` stays on agent 5.
  - Agent 5 drops → agent 7 is granted next (`ptr = 6`).
- **Hold saturation:** one agent requests for 300 cycles → `hold_timeout` rises exactly when `hold_cnt` reaches 255, stays high, `hold_cnt` stays at 255, and the grant is not revoked.
- **Idle and wrap:**
  - Agent 7 is granted, then `r = 0` → `g = 0`, `hold_cnt = 0`.
  - Then `r = 8'b1000_0001` (agents 0 and 7) → agent 0 is granted (`ptr` wrapped to 0).
- **Async reset mid-hold:** assert `reset_n` low between clock edges while agent 3 holds → all outputs go to 0 immediately. Release reset with `r = 8'hFF` → agent 0 is granted on the first edge.

Source files
------------

// File: rtl/rr_sticky_arbiter_if.sv
// Status bundle published by rr_sticky_arbiter: grant qualifier, granted
// index and the hold-time tracking outputs. All signals are registered in
// the arbiter.
interface rr_sticky_arbiter_if #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 255,
  parameter int CW       = $clog2(MAX_HOLD + 1)
);
  logic                 grant_valid;
  logic [$clog2(N)-1:0] grant_id;
  logic [CW-1:0]        hold_cnt;
  logic                 hold_timeout;

  // Arbiter side: drives the status
  modport master (
    output grant_valid,
    output grant_id,
    output hold_cnt,
    output hold_timeout
  );

  // Consumer side: observes the status
  modport slave (
    input grant_valid,
    input grant_id,
    input hold_cnt,
    input hold_timeout
  );
endinterface

// File: rtl/rr_sticky_arbiter.sv
// Registered round-robin arbiter with sticky grants. The holder keeps the
// grant while it keeps requesting; on release the next requester after the
// rotation pointer wins on the same edge. Hold time is counted and flagged
// at MAX_HOLD, but the holder is never preempted.
// r/g stay plain ports so the arbiter checker can bind to them directly.
module rr_sticky_arbiter #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 255,
  parameter int CW       = $clog2(MAX_HOLD + 1)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [0:N-1]        r,
  output logic [0:N-1]        g,
  rr_sticky_arbiter_if.master stat
);

  localparam int IW = $clog2(N);

  logic [0:N-1]  g_q, g_next;
  logic [IW-1:0] id_q, id_next;
  logic          valid_q;
  logic [IW-1:0] ptr_q, ptr_next;
  logic [CW-1:0] hold_q, hold_next;
  logic          tmo_q;

  logic          keep;
  logic          found;
  logic [IW-1:0] win_id;
  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  // Rotating priority search: first requester at ptr, ptr+1, ... mod N
  always_comb begin
    found  = 1'b0;
    win_id = '0;
    sum    = '0;
    idx    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      sum = {1'b0, ptr_q} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      idx = sum[IW-1:0];
      if (!found && r[idx]) begin
        found  = 1'b1;
        win_id = idx;
      end
    end
  end

  // Keep / fresh / idle decision and hold counter update
  always_comb begin
    keep      = |(r & g_q);
    g_next    = '0;
    id_next   = '0;
    ptr_next  = ptr_q;
    hold_next = '0;
    if (keep) begin
      g_next    = g_q;
      id_next   = id_q;
      hold_next = (hold_q == CW'(MAX_HOLD)) ? hold_q : hold_q + CW'(1);
    end else if (found) begin
      g_next[win_id] = 1'b1;
      id_next        = win_id;
      ptr_next       = (win_id == IW'(N - 1)) ? '0 : win_id + IW'(1);
      hold_next      = CW'(1);
    end
  end

  // State and output registers; reset clears everything asynchronously
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      g_q     <= '0;
      id_q    <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
      hold_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      g_q     <= g_next;
      id_q    <= id_next;
      valid_q <= |g_next;
      ptr_q   <= ptr_next;
      hold_q  <= hold_next;
      tmo_q   <= (hold_next == CW'(MAX_HOLD));
    end
  end

  assign g                 = g_q;
  assign stat.grant_valid  = valid_q;
  assign stat.grant_id     = id_q;
  assign stat.hold_cnt     = hold_q;
  assign stat.hold_timeout = tmo_q;

endmodule

// File: tb/tb_rr_sticky_arbiter.sv
// Bench for rr_sticky_arbiter (N=8, MAX_HOLD=255): directed scenarios plus
// randomized traffic, every edge compared against a holder/pointer model.
module tb_rr_sticky_arbiter;

  logic       clock;
  logic       reset_n;
  logic [0:7] r;
  logic [0:7] g;

  rr_sticky_arbiter_if #(.N(8), .MAX_HOLD(255)) stat ();

  rr_sticky_arbiter #(.N(8), .MAX_HOLD(255)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .r       (r),
    .g       (g),
    .stat    (stat)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: who holds, where rotation starts, how long held
  logic       m_has;
  logic [2:0] m_holder;
  logic [2:0] m_ptr;
  int         m_hold;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_has    = 1'b0;
    m_holder = 3'd0;
    m_ptr    = 3'd0;
    m_hold   = 0;
  endtask

  task automatic model_edge(input logic [0:7] rv);
    logic       hit;
    logic [2:0] cand;
    if (m_has && rv[m_holder]) begin
      if (m_hold < 255) m_hold++;
    end else begin
      hit = 1'b0;
      for (int k = 0; k < 8; k++) begin
        cand = m_ptr + 3'(k);
        if (!hit && rv[cand]) begin
          hit      = 1'b1;
          m_holder = cand;
        end
      end
      if (hit) begin
        m_has  = 1'b1;
        m_ptr  = m_holder + 3'd1;
        m_hold = 1;
      end else begin
        m_has  = 1'b0;
        m_hold = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [0:7] eg;
    eg = '0;
    if (m_has) eg[m_holder] = 1'b1;
    check({tag, ".g"},       32'(g),                  32'(eg));
    check({tag, ".valid"},   32'(stat.grant_valid),   32'(m_has));
    check({tag, ".id"},      32'(stat.grant_id),      m_has ? 32'(m_holder) : 32'd0);
    check({tag, ".hold"},    32'(stat.hold_cnt),      32'(m_hold));
    check({tag, ".timeout"}, 32'(stat.hold_timeout),  32'(m_hold == 255));
  endtask

  task automatic edge_check(input string tag);
    @(posedge clock);
    model_edge(r);
    #1;
    check_all(tag);
  endtask

  task automatic cycle(input logic [0:7] rv, input string tag);
    @(negedge clock);
    r = rv;
    edge_check(tag);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    r       = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_all("reset");
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [0:7] rv;
    logic [2:0] j;
    reset_n = 1'b0;
    r       = '0;
    model_reset();

    // Reset then single requester (agent 2)
    do_reset();
    cycle(8'b0010_0000, "single");
    check("single_id", 32'(stat.grant_id), 32'd2);
    check("single_hold", 32'(stat.hold_cnt), 32'd1);

    // Rotation: all request, each holder drops for one cycle
    do_reset();
    cycle(8'hFF, "rot0");
    check("rot_first", 32'(stat.grant_id), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      rv = 8'hFF;
      j  = 3'(i - 1);
      rv[j] = 1'b0;
      cycle(rv, "rot");
      check("rot_order", 32'(stat.grant_id), 32'(i % 8));
      check("rot_valid", 32'(stat.grant_valid), 32'd1);
    end

    // Stickiness: agent 5 holds while 1 and 7 wait, then 7 wins
    cycle(8'b0000_0100, "stick5");
    check("stick_first", 32'(stat.grant_id), 32'd5);
    for (int i = 0; i < 10; i++) begin
      cycle(8'b0100_0101, "sticky");
      check("sticky_id", 32'(stat.grant_id), 32'd5);
    end
    cycle(8'b0100_0001, "stick_rel");
    check("stick_next", 32'(stat.grant_id), 32'd7);

    // Idle then wrap of pointer to 0
    cycle(8'h00, "idle");
    check("idle_g", 32'(g), 32'd0);
    check("idle_hold", 32'(stat.hold_cnt), 32'd0);
    cycle(8'b1000_0001, "wrap");
    check("wrap_id", 32'(stat.grant_id), 32'd0);

    // Hold saturation: agent 3 requests for 300 cycles
    for (int i = 1; i <= 300; i++) begin
      cycle(8'b0001_0000, "sat");
      if (i == 254) check("sat_pre", 32'(stat.hold_timeout), 32'd0);
      if (i == 255) check("sat_rise", 32'(stat.hold_timeout), 32'd1);
    end
    check("sat_cnt", 32'(stat.hold_cnt), 32'd255);
    check("sat_tmo", 32'(stat.hold_timeout), 32'd1);
    check("sat_id", 32'(stat.grant_id), 32'd3);

    // Async reset mid-hold, between edges
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all("async");
    check("async_g", 32'(g), 32'd0);
    @(negedge clock);
    r       = 8'hFF;
    reset_n = 1'b1;
    edge_check("post_reset");
    check("post_reset_id", 32'(stat.grant_id), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      case ($urandom_range(0, 3))
        0: rv = r;
        1: rv = 8'($urandom());
        2: begin
          rv = r;
          if (m_has) rv[m_holder] = 1'b0;
        end
        default: begin
          rv = '0;
          j  = 3'($urandom_range(0, 7));
          if ($urandom_range(0, 3) != 0) rv[j] = 1'b1;
        end
      endcase
      cycle(rv, "rand");
      check("rand_onehot0", 32'($onehot0(g)), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
